// File: rtl/serial_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_loader_if
//  Purpose  : Serial-in handshake and D/E load bus of the serial loader.
//  Revision : 1.0
// ============================================================================
interface serial_loader_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             bit_valid;
    logic             sin;
    logic [WIDTH-1:0] D;
    logic             E;
    logic             busy;

    modport master (
        output start,
        output bit_valid,
        output sin,
        input  D,
        input  E,
        input  busy
    );

    modport slave (
        input  start,
        input  bit_valid,
        input  sin,
        output D,
        output E,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_loader.sv
`default_nettype none
// ============================================================================
//  Module   : serial_loader
//  Purpose  : Assembles WIDTH serial bits MSB-first and presents the word on
//             D with a one-cycle load enable E for a downstream enable flop.
//  Revision : 1.0
// ============================================================================
module serial_loader #(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    serial_loader_if.slave bus
);

    localparam int C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_d;
    logic               r_e;

    state_t             w_state_nx;
    logic [C_CNT_W-1:0] w_cnt_nx;
    logic [WIDTH-1:0]   w_shift_nx;
    logic [WIDTH-1:0]   w_d_nx;
    logic               w_e_nx;
    logic [WIDTH-1:0]   w_shifted;

    assign w_shifted = {r_shift[WIDTH-2:0], bus.sin};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_d     <= '0;
            r_e     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_d     <= w_d_nx;
            r_e     <= w_e_nx;
        end
    end

    // D holds everywhere except on the edge that enters LOAD.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_d_nx     = r_d;
        w_e_nx     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_SHIFT;
                    w_cnt_nx   = '0;
                    w_shift_nx = '0;
                end
            end
            S_SHIFT: begin
                if (bus.bit_valid) begin
                    w_shift_nx = w_shifted;
                    w_cnt_nx   = r_cnt + C_CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        w_state_nx = S_LOAD;
                        w_d_nx     = w_shifted;
                        w_e_nx     = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.D    = r_d;
    assign bus.E    = r_e;
    assign bus.busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_loader
//  Purpose  : Directed vector bench for serial_loader with a flopenr model.
//  Revision : 1.0
// ============================================================================
module tb_serial_loader;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_loader_if #(.WIDTH(W)) bus ();

    serial_loader #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream enable register fed by D/E
    logic [W-1:0] q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else if (bus.E) q <= bus.D;
    end

    typedef struct {
        logic         rst_n;
        logic         st;
        logic         bv;
        logic         s;
        logic [W-1:0] d;
        logic         e;
        logic         b;
        logic [W-1:0] q;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pulse = 0;

    function automatic void add_row(logic rst_n, logic st, logic bv, logic s,
                                    logic [W-1:0] d, logic e, logic b, logic [W-1:0] qv);
        vec_t v;
        v.rst_n = rst_n; v.st = st; v.bv = bv; v.s = s;
        v.d = d; v.e = e; v.b = b; v.q = qv;
        tbl.push_back(v);
    endfunction

    // One word: start cycle, WIDTH bits (optional gap), then the LOAD cycle.
    function automatic void add_word(logic [W-1:0] w, logic [W-1:0] prev,
                                     int gap_after, int gap_len, logic st_busy);
        add_row(1'b1, 1'b1, 1'b0, 1'b0, prev, 1'b0, 1'b1, prev);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1)
                add_row(1'b1, st_busy, 1'b1, w[W-1-i], w, 1'b1, 1'b1, prev);
            else
                add_row(1'b1, st_busy, 1'b1, w[W-1-i], prev, 1'b0, 1'b1, prev);
            if (i == gap_after)
                for (int g = 0; g < gap_len; g++)
                    add_row(1'b1, st_busy, 1'b0, (g % 2 == 0), prev, 1'b0, 1'b1, prev);
        end
        add_row(1'b1, st_busy, st_busy, 1'b1, w, 1'b0, 1'b0, w);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(logic st, logic bv, logic s);
        bus.start = st; bus.bit_valid = bv; bus.sin = s;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) cyc(1'b0, 1'b1, w[i]);
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.bit_valid = 1'b0; bus.sin = 1'b0;

        // Power-on reset, then idle
        add_row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        add_row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) add_row(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        // Continuous 0xA5
        add_word(8'hA5, 8'h00, -1, 0, 1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5);
        add_row(1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5);
        // Gapped 0x3C, three idle cycles after the third bit
        add_word(8'h3C, 8'hA5, 2, 3, 1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C);
        // 0x0F with start held high throughout SHIFT and LOAD
        add_word(8'h0F, 8'h3C, -1, 0, 1'b1);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h0F);
        add_row(1'b1, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h0F);
        // Back-to-back 0x12 then 0x34
        add_word(8'h12, 8'h0F, -1, 0, 1'b0);
        add_word(8'h34, 8'h12, -1, 0, 1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 8'h34);

        #2;
        chk("reset_D", 32'(bus.D), 32'h0);
        chk("reset_E", 32'(bus.E), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);

        for (int r = 0; r < tbl.size(); r++) begin
            reset = tbl[r].rst_n;
            cyc(tbl[r].st, tbl[r].bv, tbl[r].s);
            if (bus.E === 1'b1) n_pulse++;
            chk($sformatf("row%0d_D", r), 32'(bus.D), 32'(tbl[r].d));
            chk($sformatf("row%0d_E", r), 32'(bus.E), 32'(tbl[r].e));
            chk($sformatf("row%0d_busy", r), 32'(bus.busy), 32'(tbl[r].b));
            chk($sformatf("row%0d_Q", r), 32'(q), 32'(tbl[r].q));
        end
        chk("pulse_count", 32'(n_pulse), 32'd5);

        // Load 0xFF, then reset asynchronously partway through the next word
        cyc(1'b1, 1'b0, 1'b0);
        shift_word(8'hFF);
        chk("ff_E", 32'(bus.E), 32'h1);
        chk("ff_D", 32'(bus.D), 32'hFF);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        chk("mid_busy_before", 32'(bus.busy), 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("midrst_D", 32'(bus.D), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_E", 32'(bus.E), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk($sformatf("post_rst%0d_E", i), 32'(bus.E), 32'h0);
            chk($sformatf("post_rst%0d_busy", i), 32'(bus.busy), 32'h0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        shift_word(8'h81);
        chk("w81_E", 32'(bus.E), 32'h1);
        chk("w81_D", 32'(bus.D), 32'h81);
        cyc(1'b0, 1'b0, 1'b0);
        chk("w81_E_drop", 32'(bus.E), 32'h0);
        chk("w81_Q", 32'(q), 32'h81);

        // Reset while in LOAD drops E immediately
        cyc(1'b1, 1'b0, 1'b0);
        shift_word(8'h55);
        chk("load55_E", 32'(bus.E), 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("loadrst_E", 32'(bus.E), 32'h0);
        chk("loadrst_D", 32'(bus.D), 32'h0);
        chk("loadrst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("after_loadrst_E", 32'(bus.E), 32'h0);
        chk("after_loadrst_D", 32'(bus.D), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_loader.md
# serial_loader

Upstream stage for an enable-flop register (flopenr-style D/E/Q). Collects WIDTH serial bits MSB-first under a start/bit_valid protocol, then presents the assembled word on D with a one-cycle load enable E. The downstream register captures D on the rising edge where E is high. Between loads, D and E never change, so the downstream register holds its value.

## Interface
- WIDTH, 8, bits per word; must be ≥ 2.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, independent of clk.
- start  input  1  request to begin a new word; sampled only in IDLE.
- bit_valid  input  1  qualifies sin; sampled only in SHIFT.
- sin  input  1  serial data bit, MSB first.
- D  output  WIDTH  assembled word to downstream register; registered.
- E  output  1  one-cycle load enable to downstream register; registered.
- busy  output  1  high in SHIFT and LOAD.

## Operation
- Reset values (reset=0): state=IDLE, D=0, E=0, busy=0, bit counter=0, shift register=0.
- States:
  - IDLE: E=0, busy=0.
    - start=1 at an edge → SHIFT; clears the counter and shift register.
    - start=0 → stay in IDLE.
  - SHIFT: busy=1.
    - On each edge with bit_valid=1: shift register ← {shift[WIDTH-2:0], sin}; counter ← counter+1.
    - bit_valid=0 → no change; gaps of any length are allowed.
    - When the valid bit arrives with counter=WIDTH-1 → LOAD. On that same edge, D ← {shift[WIDTH-2:0], sin} and E ← 1.
  - LOAD: busy=1, E=1 for exactly one cycle.
    - Next edge → IDLE with E ← 0.
    - start and bit_valid are ignored in LOAD.
- D changes only on the edge that enters LOAD; it holds at all other times, including IDLE and SHIFT.
- start is ignored whenever busy=1. A request is not queued.
- sin is ignored whenever bit_valid=0 or the state is not SHIFT.
- Counter width: clog2(WIDTH) bits. The counter never wraps inside SHIFT, because the LOAD transition occurs at WIDTH-1.
- Reset asserted mid-SHIFT or in LOAD:
  - Immediate return to the reset state and D=0.
  - Partial word is discarded and no E pulse is produced.
  - If E was high, it drops asynchronously.

## Timing
- Start accepted at edge t0 → busy=1 after t0.
- The earliest first bit is sampled at t0+1.
- With bit_valid continuously high:
  - Bits are sampled at t0+1 … t0+WIDTH.
  - E=1 and the new D are valid after t0+WIDTH.
  - E=0 and busy=0 after t0+WIDTH+1.
  - Total latency from start to E is WIDTH+1 edges.
- Each cycle of bit_valid=0 in SHIFT delays E by one cycle.
- The downstream register captures D at edge t0+WIDTH+1, the only edge with E=1.
- Back-to-back words:
  - start=1 during the cycle after LOAD (IDLE) is accepted.
  - Minimum spacing between E pulses is WIDTH+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset release is synchronous-safe: the first state change occurs at the first rising edge with reset=1.

## Test plan
- Power-on reset:
  - reset=0 for 2 cycles → D=0, E=0, busy=0.
  - Release with start=0 for 5 cycles → outputs unchanged.
- Continuous load of 0xA5 (WIDTH=8):
  - start pulse, then sin=1,0,1,0,0,1,0,1 with bit_valid=1.
  - Required: E high for exactly one cycle, 9 edges after start; D=0xA5 and stays 0xA5 afterwards.
  - A flopenr driven by D/E shows Q=0xA5 after the E edge and holds it.
- Gapped input:
  - Load 0x3C with bit_valid=0 for 3 cycles between bits 2 and 3.
  - Required: E asserts 3 cycles later than in the continuous case; D=0x3C.
  - sin toggled during the gaps has no effect.
- Start while busy:
  - Assert start repeatedly during SHIFT and LOAD of word 0x0F.
  - Required: exactly one E pulse and D=0x0F.
  - Returns to IDLE with busy=0 and no second word begun.
- Reset mid-operation:
  - After loading 0xFF, start a new word and drive reset=0 between clock edges after 4 bits.
  - Required: D=0 and busy=0 immediately, and no E pulse.
  - A following full word 0x81 loads correctly.
- Back-to-back:
  - Load 0x12, then assert start in the first IDLE cycle and load 0x34.
  - Required: two single-cycle E pulses 10 cycles apart; D=0x12 then 0x34.
